// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/response, branch redirect and
// the decoded-instruction handoff towards control_unit.
interface instr_fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  op;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, op,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               branch_taken, branch_target, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, op,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               branch_taken, branch_target, inst_ready
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited in-order word requests,
// buffers tagged responses and drops stale ones after a branch redirect.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_stage_if.master bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int DIS_W = $clog2(2 * DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [DIS_W-1:0] dis_t;

    logic [31:0] pc_q, pc_d;
    logic [31:0] fifo_pc_q   [DEPTH];
    logic [31:0] fifo_pc_d   [DEPTH];
    logic [31:0] fifo_inst_q [DEPTH];
    logic [31:0] fifo_inst_d [DEPTH];
    logic [31:0] pcq_q       [DEPTH];
    logic [31:0] pcq_d       [DEPTH];
    ptr_t        head_q, head_d, tail_q, tail_d;
    ptr_t        pcq_head_q, pcq_head_d, pcq_tail_q, pcq_tail_d;
    cnt_t        count_q, count_d;
    cnt_t        live_q, live_d;
    dis_t        discard_q, discard_d;

    logic        inst_valid_w;
    logic        req_valid_w;
    logic        accept, pop, rsp_drop, rsp_keep, rsp_owned;
    logic [31:0] inst_w;
    logic        unused_target_lsbs;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign inst_valid_w = (count_q != '0);
    assign req_valid_w  = !rst && !bus.branch_taken &&
                          ((int'(count_q) + int'(live_q)) < DEPTH);
    assign accept       = req_valid_w && bus.imem_req_ready;
    assign pop          = inst_valid_w && bus.inst_ready;
    assign rsp_owned    = bus.imem_rsp_valid && (discard_q != '0 || live_q != '0);
    assign rsp_drop     = bus.imem_rsp_valid && (discard_q != '0);
    // Responses are owed to discarded requests first, since those were issued earlier.
    assign rsp_keep     = bus.imem_rsp_valid && (discard_q == '0) && (live_q != '0);

    assign unused_target_lsbs = ^bus.branch_target[1:0];

    // NOTE: every _d gets its _q as a default before any branch, so no latch is inferred.
    always_comb begin
        pc_d        = pc_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;
        pcq_d       = pcq_q;
        head_d      = head_q;
        tail_d      = tail_q;
        pcq_head_d  = pcq_head_q;
        pcq_tail_d  = pcq_tail_q;
        count_d     = count_q;
        live_d      = live_q;
        discard_d   = discard_q;

        if (bus.branch_taken) begin
            pc_d       = {bus.branch_target[31:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            pcq_head_d = '0;
            pcq_tail_d = '0;
            count_d    = '0;
            live_d     = '0;
            discard_d  = discard_q + dis_t'(live_q) - dis_t'(rsp_owned);
        end else begin
            if (accept) begin
                pc_d              = pc_q + 32'd4;
                pcq_d[pcq_tail_q] = pc_q;
                pcq_tail_d        = ptr_inc(pcq_tail_q);
            end
            if (rsp_drop) begin
                discard_d = discard_q - 1'b1;
            end
            if (rsp_keep) begin
                fifo_pc_d[tail_q]   = pcq_q[pcq_head_q];
                fifo_inst_d[tail_q] = bus.imem_rsp_data;
                tail_d              = ptr_inc(tail_q);
                pcq_head_d          = ptr_inc(pcq_head_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            live_d  = live_q + cnt_t'(accept) - cnt_t'(rsp_keep);
            count_d = count_q + cnt_t'(rsp_keep) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            pcq_head_q <= '0;
            pcq_tail_q <= '0;
            count_q    <= '0;
            live_q     <= '0;
            discard_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            pcq_head_q <= pcq_head_d;
            pcq_tail_q <= pcq_tail_d;
            count_q    <= count_d;
            live_q     <= live_d;
            discard_q  <= discard_d;
        end
    end

    // NOTE: storage arrays are not reset; entries are only read when count/live mark them valid.
    always_ff @(posedge clk) begin
        fifo_pc_q   <= fifo_pc_d;
        fifo_inst_q <= fifo_inst_d;
        pcq_q       <= pcq_d;
    end

    assign inst_w             = inst_valid_w ? fifo_inst_q[head_q] : '0;
    assign bus.imem_req_valid = req_valid_w;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = inst_valid_w;
    assign bus.inst           = inst_w;
    assign bus.inst_pc        = inst_valid_w ? fifo_pc_q[head_q] : '0;
    assign bus.op             = inst_w[6:0];

    a_rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
        bus.imem_rsp_valid |-> (live_q != '0 || discard_q != '0));

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized self-checking bench for instr_fetch_stage: an in-order variable-latency
// memory, a program-order scoreboard and a monitor comparing every delivered word.
module tb_instr_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    typedef struct { logic [31:0] data; int due; } mem_rsp_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

    logic clk = 1'b0;
    logic rst;

    instr_fetch_stage_if bus ();

    instr_fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Stimulus knobs
    logic        rst_knob = 1'b1;
    int          rdy_pct = 100, req_rdy_pct = 100, br_pct = 0;
    int          lat_min = 1, lat_max = 1;
    logic        force_br = 1'b0, collide_br = 1'b0, collided = 1'b0;
    logic        track_first = 1'b0;
    logic [31:0] br_tgt = '0;

    // Environment / model state
    mem_rsp_t    mem_q[$];
    exp_t        exp_q[$];
    int          cyc = 0, last_due = 0, acc_cnt = 0, n_delivered = 0;
    logic [31:0] exp_fetch_pc = RESET_PC;
    logic [31:0] last_acc = '0;
    logic        saw_wrap = 1'b0, prev_rst_drv = 1'b0;
    logic        want_valid = 1'b0;
    logic [31:0] want_pc = '0;

    task automatic check(string name, logic ok, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] mem_word(logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0033;
            32'h0000_0004: return 32'h0000_0003;
            32'h0000_0008: return 32'h0000_0023;
            default:       return (a * 32'h9E37_79B9) ^ 32'h0000_5A5A;
        endcase
    endfunction

    task automatic step();
        int          lat, due;
        logic        br;
        logic [31:0] addr;
        mem_rsp_t    r;
        exp_t        e;
        @(negedge clk);
        rst = rst_knob;
        if (!rst && prev_rst_drv) begin
            mem_q.delete();
            last_due = cyc;
        end
        bus.inst_ready     = ($urandom_range(99) < rdy_pct);
        bus.imem_req_ready = ($urandom_range(99) < req_rdy_pct);
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_q[0].data;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        br = 1'b0;
        if (!rst) begin
            if (force_br) br = 1'b1;
            else if (collide_br && bus.imem_rsp_valid && bus.inst_valid && bus.inst_ready) begin
                br = 1'b1;
                collided = 1'b1;
            end else if (br_pct > 0 && mem_q.size() <= 2 * DEPTH && $urandom_range(99) < br_pct) begin
                br = 1'b1;
                br_tgt = $urandom;
            end
        end
        force_br = 1'b0;
        bus.branch_taken  = br;
        bus.branch_target = br ? br_tgt : $urandom;
        #1;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            addr = bus.imem_req_addr;
            check("req_addr", addr == exp_fetch_pc, addr, exp_fetch_pc);
            if (addr == 32'h0 && last_acc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
            last_acc = addr;
            lat = $urandom_range(lat_max, lat_min);
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            r.data = mem_word(addr);
            r.due  = due;
            mem_q.push_back(r);
            last_due = due;
            e.pc   = exp_fetch_pc;
            e.inst = mem_word(exp_fetch_pc);
            exp_q.push_back(e);
            exp_fetch_pc += 32'd4;
            acc_cnt++;
        end
        if (bus.imem_rsp_valid) void'(mem_q.pop_front());
        if (br) begin
            check("no_req_on_redirect", !bus.imem_req_valid, 32'(bus.imem_req_valid), 32'h0);
            exp_fetch_pc = {br_tgt[31:2], 2'b00};
        end
        if (rst) exp_fetch_pc = RESET_PC;
        prev_rst_drv = rst;
        cyc++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(int n);
        rst_knob = 1'b1;
        run(n);
        rst_knob = 1'b0;
    endtask

    // Monitor: compares every delivered word against the program-order scoreboard.
    logic        prev_rst = 1'b0, prev_br = 1'b0, prev_hold = 1'b0;
    logic [31:0] prev_inst = '0, prev_pc = '0;

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] einst;
        #2;
        if (rst)
            check("req_valid_in_reset", !bus.imem_req_valid, 32'(bus.imem_req_valid), 32'h0);
        if (prev_rst) begin
            check("reset_inst_valid", !bus.inst_valid, 32'(bus.inst_valid), 32'h0);
            check("reset_inst", bus.inst == 32'h0, bus.inst, 32'h0);
            check("reset_inst_pc", bus.inst_pc == 32'h0, bus.inst_pc, 32'h0);
            check("reset_op", bus.op == 7'h0, 32'(bus.op), 32'h0);
        end
        if (prev_br)
            check("empty_after_redirect", !bus.inst_valid, 32'(bus.inst_valid), 32'h0);
        if (prev_hold && !rst) begin
            check("hold_valid", bus.inst_valid, 32'(bus.inst_valid), 32'h1);
            check("hold_inst", bus.inst == prev_inst, bus.inst, prev_inst);
            check("hold_pc", bus.inst_pc == prev_pc, bus.inst_pc, prev_pc);
        end
        if (!rst && bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 1'b0, bus.inst_pc, 32'h0);
            end else begin
                e = exp_q.pop_front();
                einst = e.inst;
                check("pop_pc", bus.inst_pc == e.pc, bus.inst_pc, e.pc);
                check("pop_inst", bus.inst == einst, bus.inst, einst);
                check("pop_op", bus.op == einst[6:0], 32'(bus.op), 32'(einst[6:0]));
            end
            if (want_valid) begin
                check("first_after_redirect", bus.inst_pc == want_pc, bus.inst_pc, want_pc);
                want_valid = 1'b0;
            end
            n_delivered++;
        end
        if (rst || bus.branch_taken) exp_q.delete();
        if (!rst && bus.branch_taken && track_first) begin
            want_valid = 1'b1;
            want_pc    = {bus.branch_target[31:2], 2'b00};
        end
        prev_rst  = rst;
        prev_br   = !rst && bus.branch_taken;
        prev_hold = !rst && !bus.branch_taken && bus.inst_valid && !bus.inst_ready;
        prev_inst = bus.inst;
        prev_pc   = bus.inst_pc;
    end

    initial begin
        rst                = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.branch_taken   = 1'b0;
        bus.branch_target  = '0;
        bus.inst_ready     = 1'b0;

        // Reset and first fetch with a 1-cycle memory
        do_reset(3);
        run(12);

        // Backpressure: only DEPTH requests may issue while downstream stalls
        do_reset(2);
        rdy_pct = 0;
        acc_cnt = 0;
        run(10);
        check("bp_request_count", acc_cnt == DEPTH, 32'(acc_cnt), 32'(DEPTH));
        rdy_pct = 100;
        run(10);

        // Redirect with two responses in flight on a 3-cycle memory
        do_reset(2);
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 20 && mem_q.size() != 2; i++) step();
        check("two_in_flight", mem_q.size() == 2, 32'(mem_q.size()), 32'h2);
        track_first = 1'b1;
        br_tgt      = 32'h0000_0103;
        force_br    = 1'b1;
        run(1);
        track_first = 1'b0;
        run(20);
        check("redirect_first_seen", !want_valid, 32'(want_valid), 32'h0);

        // Response, pop and redirect in the same cycle
        lat_min    = 1;
        lat_max    = 1;
        collided   = 1'b0;
        collide_br = 1'b1;
        br_tgt     = 32'h0000_0400;
        for (int i = 0; i < 100 && !collided; i++) step();
        collide_br = 1'b0;
        check("collision_seen", collided, 32'(collided), 32'h1);
        run(10);

        // Address wrap-around
        saw_wrap = 1'b0;
        br_tgt   = 32'hFFFF_FFF8;
        force_br = 1'b1;
        run(12);
        check("pc_wrap", saw_wrap, 32'(saw_wrap), 32'h1);

        // Reset while stalled with requests in flight
        lat_min = 3;
        lat_max = 3;
        rdy_pct = 0;
        run(4);
        do_reset(3);
        rdy_pct = 100;
        lat_min = 1;
        lat_max = 1;
        run(12);

        // Randomized traffic with occasional redirects
        lat_min     = 1;
        lat_max     = 4;
        rdy_pct     = 70;
        req_rdy_pct = 70;
        br_pct      = 4;
        run(3000);
        br_pct = 0;
        run(20);
        check("delivered_volume", n_delivered > 500, 32'(n_delivered), 32'd500);

        #5;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
